// File: rtl/cfu_mac_sequencer.sv
// cfu_mac_sequencer: runs one codebook-MAC job as RST, codebook, (PUSH, MAC*)xN, READ on the CFU port.
// Optional CFU_SEQ_CHECK_EN: checks every acknowledge payload and aborts the job on a mismatch.
`default_nettype none

module cfu_mac_sequencer (
   input  logic        clk_i,
   input  logic        reset_ni,
   input  logic        job_valid_i,
   output logic        job_ready_o,
   input  logic [1:0]  job_mode_i,
   input  logic [31:0] job_cb0_i,
   input  logic [31:0] job_cb1_i,
   input  logic [31:0] job_cb2_i,
   input  logic [31:0] job_cb3_i,
   input  logic [15:0] job_nblocks_i,
   input  logic        data_valid_i,
   output logic        data_ready_o,
   input  logic [31:0] data_0_i,
   input  logic [31:0] data_1_i,
   output logic        cfu_cmd_valid_o,
   input  logic        cfu_cmd_ready_i,
   output logic [9:0]  cfu_function_id_o,
   output logic [31:0] cfu_inputs_0_o,
   output logic [31:0] cfu_inputs_1_o,
   input  logic        cfu_rsp_valid_i,
   output logic        cfu_rsp_ready_o,
   input  logic [31:0] cfu_rsp_payload_i,
   output logic        res_valid_o,
   input  logic        res_ready_i,
   output logic [31:0] res_data_o,
   output logic        res_err_o
);

   localparam logic [9:0] FID_ALU_RST = {7'h48, 3'b000};
   localparam logic [9:0] FID_CB2     = {7'h20, 3'b000};
   localparam logic [9:0] FID_CB4     = {7'h28, 3'b000};
   localparam logic [9:0] FID_CB16    = {7'h38, 3'b000};
   localparam logic [9:0] FID_PUSH    = {7'h10, 3'b000};
   localparam logic [9:0] FID_MAC     = {7'h40, 3'b000};
   localparam logic [9:0] FID_READ    = {7'h50, 3'b000};

   typedef enum logic [2:0] {
      S_IDLE, S_RST, S_CB, S_PUSH, S_MAC, S_READ, S_RESULT
   } state_e;

   typedef enum logic [1:0] {
      PH_FETCH, PH_ISSUE, PH_WAIT
   } phase_e;

   state_e      state_q, state_d;
   phase_e      phase_q, phase_d;
   logic [1:0]  mode_q, mode_d;
   logic [31:0] cb0_q, cb0_d, cb1_q, cb1_d, cb2_q, cb2_d, cb3_q, cb3_d;
   logic [15:0] blocks_q, blocks_d;
   logic [1:0]  mac_idx_q, mac_idx_d;
   logic        cb_half_q, cb_half_d;
   logic [9:0]  fid_q, fid_d;
   logic [31:0] in0_q, in0_d, in1_q, in1_d;
   logic [31:0] res_data_q, res_data_d;
   logic        res_err_q, res_err_d;

   logic        w_cmd_state;
   logic [1:0]  w_mac_last;
   logic [15:0] w_blocks_dec;
   logic        w_more_blocks;
   logic        w_ack_bad;

   assign w_cmd_state   = (state_q == S_RST) || (state_q == S_CB) || (state_q == S_PUSH) ||
                          (state_q == S_MAC) || (state_q == S_READ);
   assign w_mac_last    = (mode_q == 2'd2) ? 2'd1 : 2'd3;
   assign w_blocks_dec  = blocks_q - 16'd1;
   assign w_more_blocks = (state_q == S_MAC) ? (w_blocks_dec != 16'd0) : (blocks_q != 16'd0);

`ifdef CFU_SEQ_CHECK_EN
   logic [31:0] w_exp_ack;

   always_comb begin
      w_exp_ack = 32'h0;
      case (fid_q)
         FID_CB2:  w_exp_ack = 32'hAABB2202;
         FID_CB4:  w_exp_ack = 32'hAABB4404;
         FID_CB16: w_exp_ack = cb_half_q ? 32'hAABB16B1 : 32'hAABB16A0;
         FID_PUSH: w_exp_ack = 32'hDEAD0000;
         FID_MAC:  w_exp_ack = 32'hABCD0001;
         default:  w_exp_ack = 32'h0;
      endcase
   end

   // The MAC_READ payload is the result itself, so it is never checked.
   assign w_ack_bad = (state_q != S_READ) && (cfu_rsp_payload_i != w_exp_ack);
`else
   assign w_ack_bad = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      phase_d    = phase_q;
      mode_d     = mode_q;
      cb0_d      = cb0_q;
      cb1_d      = cb1_q;
      cb2_d      = cb2_q;
      cb3_d      = cb3_q;
      blocks_d   = blocks_q;
      mac_idx_d  = mac_idx_q;
      cb_half_d  = cb_half_q;
      fid_d      = fid_q;
      in0_d      = in0_q;
      in1_d      = in1_q;
      res_data_d = res_data_q;
      res_err_d  = res_err_q;

      case (state_q)
         S_IDLE: begin
            if (job_valid_i) begin
               mode_d     = job_mode_i;
               cb0_d      = job_cb0_i;
               cb1_d      = job_cb1_i;
               cb2_d      = job_cb2_i;
               cb3_d      = job_cb3_i;
               blocks_d   = job_nblocks_i;
               mac_idx_d  = 2'd0;
               cb_half_d  = 1'b0;
               res_err_d  = 1'b0;
               res_data_d = 32'h0;
               fid_d      = FID_ALU_RST;
               in0_d      = 32'h0;
               in1_d      = 32'h0;
               state_d    = S_RST;
               phase_d    = PH_ISSUE;
            end
         end

         S_RESULT: begin
            if (res_ready_i) begin
               state_d = S_IDLE;
            end
         end

         default: begin
            case (phase_q)
               PH_FETCH: begin
                  if (data_valid_i) begin
                     in0_d   = data_0_i;
                     in1_d   = data_1_i;
                     fid_d   = (state_q == S_PUSH) ? FID_PUSH : FID_MAC;
                     phase_d = PH_ISSUE;
                  end
               end

               PH_ISSUE: begin
                  if (cfu_cmd_ready_i) begin
                     phase_d = PH_WAIT;
                  end
               end

               PH_WAIT: begin
                  if (cfu_rsp_valid_i) begin
                     if (w_ack_bad) begin
                        res_err_d  = 1'b1;
                        res_data_d = cfu_rsp_payload_i;
                        state_d    = S_RESULT;
                     end else begin
                        case (state_q)
                           S_RST: begin
                              if (mode_q == 2'd3) begin
                                 res_err_d  = 1'b1;
                                 res_data_d = 32'h0;
                                 state_d    = S_RESULT;
                              end else begin
                                 fid_d   = (mode_q == 2'd0) ? FID_CB2 :
                                           (mode_q == 2'd1) ? FID_CB4 : FID_CB16;
                                 in0_d   = cb0_q;
                                 in1_d   = (mode_q == 2'd2) ? cb1_q : 32'h0;
                                 state_d = S_CB;
                                 phase_d = PH_ISSUE;
                              end
                           end
                           S_PUSH: begin
                              state_d = S_MAC;
                              phase_d = PH_FETCH;
                           end
                           S_READ: begin
                              res_data_d = cfu_rsp_payload_i;
                              state_d    = S_RESULT;
                           end
                           default: begin
                              // 16-cluster codebooks always go out as a pair of halves.
                              if ((state_q == S_CB) && (mode_q == 2'd2) && !cb_half_q) begin
                                 cb_half_d = 1'b1;
                                 in0_d     = cb2_q;
                                 in1_d     = cb3_q;
                                 phase_d   = PH_ISSUE;
                              end else if ((state_q == S_MAC) && (mac_idx_q != w_mac_last)) begin
                                 mac_idx_d = mac_idx_q + 2'd1;
                                 phase_d   = PH_FETCH;
                              end else begin
                                 if (state_q == S_MAC) begin
                                    mac_idx_d = 2'd0;
                                    blocks_d  = w_blocks_dec;
                                 end
                                 if (w_more_blocks) begin
                                    state_d = S_PUSH;
                                    phase_d = PH_FETCH;
                                 end else begin
                                    fid_d   = FID_READ;
                                    in0_d   = 32'h0;
                                    in1_d   = 32'h0;
                                    state_d = S_READ;
                                    phase_d = PH_ISSUE;
                                 end
                              end
                           end
                        endcase
                     end
                  end
               end

               default: begin
                  state_d = S_IDLE;
               end
            endcase
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q    <= S_IDLE;
         phase_q    <= PH_ISSUE;
         mode_q     <= 2'd0;
         cb0_q      <= 32'h0;
         cb1_q      <= 32'h0;
         cb2_q      <= 32'h0;
         cb3_q      <= 32'h0;
         blocks_q   <= 16'd0;
         mac_idx_q  <= 2'd0;
         cb_half_q  <= 1'b0;
         fid_q      <= 10'h0;
         in0_q      <= 32'h0;
         in1_q      <= 32'h0;
         res_data_q <= 32'h0;
         res_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         phase_q    <= phase_d;
         mode_q     <= mode_d;
         cb0_q      <= cb0_d;
         cb1_q      <= cb1_d;
         cb2_q      <= cb2_d;
         cb3_q      <= cb3_d;
         blocks_q   <= blocks_d;
         mac_idx_q  <= mac_idx_d;
         cb_half_q  <= cb_half_d;
         fid_q      <= fid_d;
         in0_q      <= in0_d;
         in1_q      <= in1_d;
         res_data_q <= res_data_d;
         res_err_q  <= res_err_d;
      end
   end

   assign job_ready_o       = (state_q == S_IDLE);
   assign data_ready_o      = ((state_q == S_PUSH) || (state_q == S_MAC)) && (phase_q == PH_FETCH);
   assign cfu_cmd_valid_o   = w_cmd_state && (phase_q == PH_ISSUE);
   assign cfu_rsp_ready_o   = w_cmd_state && (phase_q == PH_WAIT);
   assign cfu_function_id_o = fid_q;
   assign cfu_inputs_0_o    = in0_q;
   assign cfu_inputs_1_o    = in1_q;
   assign res_valid_o       = (state_q == S_RESULT);
   assign res_data_o        = res_data_q;
   assign res_err_o         = res_err_q;

endmodule

`default_nettype wire

// File: tb/tb_cfu_mac_sequencer.sv
// tb_cfu_mac_sequencer: directed jobs against a small behavioural CFU and stream source.
`default_nettype none

module tb_cfu_mac_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        job_valid, job_ready;
   logic [1:0]  job_mode;
   logic [31:0] job_cb0, job_cb1, job_cb2, job_cb3;
   logic [15:0] job_nblocks;
   logic        data_valid, data_ready;
   logic [31:0] data_0, data_1;
   logic        cmd_valid, cmd_ready;
   logic [9:0]  fid;
   logic [31:0] in0, in1;
   logic        rsp_valid, rsp_ready;
   logic [31:0] rsp_payload;
   logic        res_valid, res_ready, res_err;
   logic [31:0] res_data;

   always #5 clk = ~clk;

   cfu_mac_sequencer dut (
      .clk_i             (clk),
      .reset_ni          (rst_n),
      .job_valid_i       (job_valid),
      .job_ready_o       (job_ready),
      .job_mode_i        (job_mode),
      .job_cb0_i         (job_cb0),
      .job_cb1_i         (job_cb1),
      .job_cb2_i         (job_cb2),
      .job_cb3_i         (job_cb3),
      .job_nblocks_i     (job_nblocks),
      .data_valid_i      (data_valid),
      .data_ready_o      (data_ready),
      .data_0_i          (data_0),
      .data_1_i          (data_1),
      .cfu_cmd_valid_o   (cmd_valid),
      .cfu_cmd_ready_i   (cmd_ready),
      .cfu_function_id_o (fid),
      .cfu_inputs_0_o    (in0),
      .cfu_inputs_1_o    (in1),
      .cfu_rsp_valid_i   (rsp_valid),
      .cfu_rsp_ready_o   (rsp_ready),
      .cfu_rsp_payload_i (rsp_payload),
      .res_valid_o       (res_valid),
      .res_ready_i       (res_ready),
      .res_data_o        (res_data),
      .res_err_o         (res_err)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int n_dready = 0;

   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) if (data_ready) n_dready <= n_dready + 1;

   // Behavioural CFU: one-cycle response. All vectors use weight code 0, so codebook entry 0 applies.
   logic [9:0]  cmd_log [$];
   logic [31:0] m_sum;
   logic [7:0]  m_cb;
   logic        m_half;
   bit          bad_push = 1'b0;

   function automatic int mac_term(input logic [31:0] a, input logic [31:0] b, input logic [7:0] cb);
      int s = 0;
      for (int k = 0; k < 4; k++) begin
         s += (int'(a[8*k +: 8]) - 128) + (int'(b[8*k +: 8]) - 128);
      end
      return s * int'(cb);
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid   <= 1'b0;
         rsp_payload <= 32'h0;
         m_sum       <= 32'h0;
         m_cb        <= 8'h0;
         m_half      <= 1'b0;
      end else begin
         if (rsp_valid && rsp_ready) rsp_valid <= 1'b0;
         if (cmd_valid && cmd_ready) begin
            cmd_log.push_back(fid);
            rsp_valid <= 1'b1;
            case (fid)
               10'h240: begin m_sum <= 32'h0; rsp_payload <= 32'h0; end
               10'h100: begin m_cb <= in0[7:0]; rsp_payload <= 32'hAABB2202; end
               10'h140: begin m_cb <= in0[7:0]; rsp_payload <= 32'hAABB4404; end
               10'h1C0: begin
                  if (!m_half) m_cb <= in0[7:0];
                  rsp_payload <= m_half ? 32'hAABB16B1 : 32'hAABB16A0;
                  m_half      <= ~m_half;
               end
               10'h080: rsp_payload <= bad_push ? 32'h12345678 : 32'hDEAD0000;
               10'h200: begin
                  m_sum       <= m_sum + 32'(mac_term(in0, in1, m_cb));
                  rsp_payload <= 32'hABCD0001;
               end
               10'h280: begin rsp_payload <= m_sum; m_sum <= 32'h0; end
               default: rsp_payload <= 32'hFFFFFFFF;
            endcase
         end
      end
   end

   // Stream source: words appended by the stimulus, consumed on handshake.
   logic [63:0] src_mem [0:63];
   int          src_n = 0;
   int          src_idx = 0;
   bit          src_flush = 1'b0;

   assign data_valid = (src_idx < src_n);
   assign data_0     = src_mem[src_idx[5:0]][63:32];
   assign data_1     = src_mem[src_idx[5:0]][31:0];

   always @(posedge clk) begin
      if (src_flush) src_idx <= src_n;
      else if (data_valid && data_ready) src_idx <= src_idx + 1;
   end

   task automatic push_word(input logic [31:0] w0, input logic [31:0] w1);
      src_mem[src_n[5:0]] = {w0, w1};
      src_n++;
   endtask

   task automatic push_block(input logic [31:0] act, input int steps);
      push_word(32'h0, 32'h0);
      for (int s = 0; s < steps; s++) push_word(act, act);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic start_job(input logic [1:0] m, input logic [31:0] c0, input logic [31:0] c1,
                            input logic [31:0] c2, input logic [31:0] c3, input logic [15:0] nb,
                            output int t_acc);
      @(negedge clk);
      job_mode = m; job_cb0 = c0; job_cb1 = c1; job_cb2 = c2; job_cb3 = c3; job_nblocks = nb;
      job_valid = 1'b1;
      check("job_ready_idle", 32'(job_ready), 32'd1);
      @(negedge clk);
      job_valid = 1'b0;
      t_acc = cyc;
   endtask

   task automatic wait_result(input int t_acc, output int lat);
      int n = 0;
      while (!res_valid && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check("result_arrives", 32'(res_valid), 32'd1);
      lat = cyc - t_acc;
   endtask

   task automatic take_result();
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      check("job_ready_after", 32'(job_ready), 32'd1);
   endtask

   task automatic wait_cmd(input logic [9:0] f);
      int n = 0;
      while (!(cmd_valid && fid == f) && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("wait_cmd", 32'(cmd_valid && fid == f), 32'd1);
   endtask

   task automatic flush_stream();
      src_flush = 1'b1;
      @(negedge clk);
      src_flush = 1'b0;
   endtask

   function automatic int count_fid(input int base, input logic [9:0] f);
      int c = 0;
      for (int i = base; i < cmd_log.size(); i++) if (cmd_log[i] == f) c++;
      return c;
   endfunction

   logic [9:0] exp_seq1 [8] = '{10'h240, 10'h140, 10'h080, 10'h200, 10'h200, 10'h200, 10'h200, 10'h280};

   initial begin
      int ta, lat, base, d0;
      rst_n = 1'b0; job_valid = 1'b0; job_mode = 2'd0; job_nblocks = 16'd0;
      job_cb0 = 32'h0; job_cb1 = 32'h0; job_cb2 = 32'h0; job_cb3 = 32'h0;
      cmd_ready = 1'b1; res_ready = 1'b0;
      repeat (3) @(negedge clk);

      check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
      check("rst_rsp_ready", 32'(rsp_ready), 32'd0);
      check("rst_data_ready", 32'(data_ready), 32'd0);
      check("rst_res_valid", 32'(res_valid), 32'd0);
      check("rst_res_err", 32'(res_err), 32'd0);
      check("rst_fid", 32'(fid), 32'd0);
      check("rst_in0", in0, 32'd0);
      check("rst_res_data", res_data, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_job_ready", 32'(job_ready), 32'd1);

      // Mode 1, zero activations: sum 0, exact command order and minimum latency.
      base = cmd_log.size();
      push_block(32'h80808080, 4);
      start_job(2'd1, 32'h04030201, 32'h0, 32'h0, 32'h0, 16'd1, ta);
      wait_result(ta, lat);
      check("m1_zero_data", res_data, 32'd0);
      check("m1_zero_err", 32'(res_err), 32'd0);
      check("m1_latency", 32'(lat), 32'd21);
      check("m1_cmd_count", 32'(cmd_log.size() - base), 32'd8);
      for (int i = 0; i < 8; i++) check("m1_cmd_order", 32'(cmd_log[base + i]), 32'(exp_seq1[i]));
      take_result();

      // Mode 1, activations of +1: 32 x 1 x 1.
      push_block(32'h81818181, 4);
      start_job(2'd1, 32'h04030201, 32'h0, 32'h0, 32'h0, 16'd1, ta);
      wait_result(ta, lat);
      check("m1_one_data", res_data, 32'd32);
      take_result();

      // Mode 2, two blocks of two steps: 2 x 16 x 2.
      base = cmd_log.size();
      push_block(32'h81818181, 2);
      push_block(32'h81818181, 2);
      start_job(2'd2, 32'h02020202, 32'h02020202, 32'h02020202, 32'h02020202, 16'd2, ta);
      wait_result(ta, lat);
      check("m2_data", res_data, 32'd64);
      check("m2_err", 32'(res_err), 32'd0);
      check("m2_latency", 32'(lat), 32'd26);
      check("m2_cb16_count", 32'(count_fid(base, 10'h1C0)), 32'd2);
      check("m2_push_count", 32'(count_fid(base, 10'h080)), 32'd2);
      check("m2_mac_count", 32'(count_fid(base, 10'h200)), 32'd4);
      check("m2_read_count", 32'(count_fid(base, 10'h280)), 32'd1);
      take_result();

      // Illegal mode: error flag, zero data, no stream consumed.
      d0 = n_dready;
      start_job(2'd3, 32'h04030201, 32'h0, 32'h0, 32'h0, 16'd1, ta);
      wait_result(ta, lat);
      check("m3_err", 32'(res_err), 32'd1);
      check("m3_data", res_data, 32'd0);
      check("m3_no_fetch", 32'(n_dready - d0), 32'd0);
      take_result();

      // Zero blocks: RST, CB, READ only; error cleared by the new job.
      base = cmd_log.size();
      d0 = n_dready;
      start_job(2'd1, 32'h04030201, 32'h0, 32'h0, 32'h0, 16'd0, ta);
      wait_result(ta, lat);
      check("nb0_data", res_data, 32'd0);
      check("nb0_err", 32'(res_err), 32'd0);
      check("nb0_no_fetch", 32'(n_dready - d0), 32'd0);
      check("nb0_cmd_count", 32'(cmd_log.size() - base), 32'd3);
      check("nb0_latency", 32'(lat), 32'd6);
      take_result();

      // Back-pressure: stall the first MAC, then hold the result.
      base = cmd_log.size();
      push_block(32'h82828282, 4);
      start_job(2'd0, 32'h00000003, 32'h0, 32'h0, 32'h0, 16'd1, ta);
      wait_cmd(10'h200);
      cmd_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("stall_valid", 32'(cmd_valid), 32'd1);
         check("stall_fid", 32'(fid), 32'h200);
         check("stall_in0", in0, 32'h82828282);
         check("stall_in1", in1, 32'h82828282);
      end
      cmd_ready = 1'b1;
      wait_result(ta, lat);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("hold_res_valid", 32'(res_valid), 32'd1);
         check("hold_res_data", res_data, 32'd192);
      end
      check("stall_cmd_count", 32'(cmd_log.size() - base), 32'd8);
      check("stall_mac_count", 32'(count_fid(base, 10'h200)), 32'd4);
      take_result();

      // Asynchronous reset in the middle of the MAC steps.
      push_block(32'h81818181, 4);
      start_job(2'd1, 32'h04030201, 32'h0, 32'h0, 32'h0, 16'd1, ta);
      wait_cmd(10'h200);
      #1 rst_n = 1'b0;
      #1;
      check("arst_cmd_valid", 32'(cmd_valid), 32'd0);
      check("arst_rsp_ready", 32'(rsp_ready), 32'd0);
      check("arst_data_ready", 32'(data_ready), 32'd0);
      check("arst_res_valid", 32'(res_valid), 32'd0);
      check("arst_fid", 32'(fid), 32'd0);
      check("arst_in0", in0, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      flush_stream();
      push_block(32'h81818181, 4);
      start_job(2'd1, 32'h04030201, 32'h0, 32'h0, 32'h0, 16'd1, ta);
      wait_result(ta, lat);
      check("post_rst_data", res_data, 32'd32);
      check("post_rst_err", 32'(res_err), 32'd0);
      take_result();

`ifdef CFU_SEQ_CHECK_EN
      // Corrupted PUSH acknowledge aborts before any MAC or MAC_READ.
      base = cmd_log.size();
      bad_push = 1'b1;
      push_block(32'h81818181, 4);
      start_job(2'd1, 32'h04030201, 32'h0, 32'h0, 32'h0, 16'd1, ta);
      wait_result(ta, lat);
      check("chk_err", 32'(res_err), 32'd1);
      check("chk_data", res_data, 32'h12345678);
      check("chk_no_read", 32'(count_fid(base, 10'h280)), 32'd0);
      check("chk_no_mac", 32'(count_fid(base, 10'h200)), 32'd0);
      take_result();
      bad_push = 1'b0;
      flush_stream();
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
